// File: rtl/axi_bridge_pkg.sv
// Shared constants and types for the SRAM-like to AXI bridge.
package axi_bridge_pkg;

  // Address / data / strobe widths of the AR, AW and W registers
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned STRB_W   = 4;
  localparam int unsigned AXSIZE_W = 3;
  localparam int unsigned AXLEN_W  = 8;

  // Default AXI ids
  localparam int unsigned AXI_ID_W_DEF = 4;
  localparam int unsigned INST_ID_DEF  = 0;
  localparam int unsigned DATA_ID_DEF  = 1;

  // Single-beat INCR bursts only
  localparam logic [1:0]         AXI_BURST_INCR = 2'b01;
  localparam logic [AXLEN_W-1:0] AXI_LEN_SINGLE = '0;

  // Request fields held while an address phase is pending
  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [AXSIZE_W-1:0] size;
  } ax_req_t;

  // SRAM byte-count code (0=1B, 1=2B, 2=4B) maps straight onto AxSIZE
  function automatic logic [AXSIZE_W-1:0] to_axsize(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/axi_bridge_wr_ch.sv
// Write path of the bridge: AW and W issue registers plus tracking of the
// single outstanding write until its B response arrives.
module axi_bridge_wr_ch
  import axi_bridge_pkg::*;
#(
  parameter int unsigned AXI_ID_W = AXI_ID_W_DEF,
  parameter int unsigned DATA_ID  = DATA_ID_DEF
) (
  input  logic                clk,
  input  logic                reset,
  // Accepted write from the data port
  input  logic                wr_go,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [1:0]          wr_size,
  input  logic [STRB_W-1:0]   wr_strb,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                idle,
  output logic                done,
  // AW channel
  output logic [ADDR_W-1:0]   awaddr,
  output logic [AXI_ID_W-1:0] awid,
  output logic [AXSIZE_W-1:0] awsize,
  output logic                awvalid,
  input  logic                awready,
  // W channel
  output logic [DATA_W-1:0]   wdata,
  output logic [STRB_W-1:0]   wstrb,
  output logic [AXI_ID_W-1:0] wid,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  // B channel
  input  logic [AXI_ID_W-1:0] bid,
  input  logic                bvalid
);

  localparam logic [AXI_ID_W-1:0] DATA_AXI_ID = AXI_ID_W'(DATA_ID);

  logic              aw_valid_q;
  ax_req_t           aw_req_q;
  logic              w_valid_q;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;
  logic              pend_q;

  // Nothing is in flight only once both beats are gone and B has returned
  assign idle = ~pend_q & ~aw_valid_q & ~w_valid_q;
  // A B response is only honoured while a write is outstanding
  assign done = bvalid & (bid == DATA_AXI_ID) & pend_q;

  assign awaddr  = aw_req_q.addr;
  assign awsize  = aw_req_q.size;
  assign awid    = DATA_AXI_ID;
  assign awvalid = aw_valid_q;

  assign wdata  = w_data_q;
  assign wstrb  = w_strb_q;
  assign wid    = DATA_AXI_ID;
  assign wlast  = 1'b1;
  assign wvalid = w_valid_q;

  // AW register: load on accept, drop on its own handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      aw_valid_q <= 1'b0;
      aw_req_q   <= '0;
    end else if (wr_go) begin
      aw_valid_q <= 1'b1;
      aw_req_q   <= '{addr: wr_addr, size: to_axsize(wr_size)};
    end else if (aw_valid_q && awready) begin
      aw_valid_q <= 1'b0;
    end
  end

  // W register: load on accept, drop independently of AW
  always_ff @(posedge clk) begin
    if (reset) begin
      w_valid_q <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else if (wr_go) begin
      w_valid_q <= 1'b1;
      w_data_q  <= wr_data;
      w_strb_q  <= wr_strb;
    end else if (w_valid_q && wready) begin
      w_valid_q <= 1'b0;
    end
  end

  // Outstanding-write flag, held until the matching B response
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= 1'b0;
    end else if (wr_go) begin
      pend_q <= 1'b1;
    end else if (done) begin
      pend_q <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_bridge.sv
// Bridge from the CPU's inst (read-only) and data (read/write) SRAM-like
// ports to one AXI master. Both ports share the AR/R channels through a
// single AR slot; writes go through axi_bridge_wr_ch. Each port keeps at
// most one transaction in flight.
// Optional feature: define AXI_BRIDGE_RDATA_BUF_EN to register data_ok and
// rdata (one extra cycle of response latency).
module axi_bridge
  import axi_bridge_pkg::*;
#(
  parameter int unsigned AXI_ID_W = AXI_ID_W_DEF,
  parameter int unsigned INST_ID  = INST_ID_DEF,
  parameter int unsigned DATA_ID  = DATA_ID_DEF
) (
  input  logic                clk,
  input  logic                reset,
  // Inst port
  input  logic                inst_sram_req,
  input  logic                inst_sram_wr,
  input  logic [1:0]          inst_sram_size,
  input  logic [ADDR_W-1:0]   inst_sram_addr,
  output logic                inst_sram_addr_ok,
  output logic                inst_sram_data_ok,
  output logic [DATA_W-1:0]   inst_sram_rdata,
  // Data port
  input  logic                data_sram_req,
  input  logic                data_sram_wr,
  input  logic [1:0]          data_sram_size,
  input  logic [STRB_W-1:0]   data_sram_wstrb,
  input  logic [ADDR_W-1:0]   data_sram_addr,
  input  logic [DATA_W-1:0]   data_sram_wdata,
  output logic                data_sram_addr_ok,
  output logic                data_sram_data_ok,
  output logic [DATA_W-1:0]   data_sram_rdata,
  // AR channel
  output logic [ADDR_W-1:0]   araddr,
  output logic [AXI_ID_W-1:0] arid,
  output logic [AXLEN_W-1:0]  arlen,
  output logic [AXSIZE_W-1:0] arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  // R channel
  input  logic [AXI_ID_W-1:0] rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  // AW channel
  output logic [ADDR_W-1:0]   awaddr,
  output logic [AXI_ID_W-1:0] awid,
  output logic [AXLEN_W-1:0]  awlen,
  output logic [AXSIZE_W-1:0] awsize,
  output logic [1:0]          awburst,
  output logic [1:0]          awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  // W channel
  output logic [DATA_W-1:0]   wdata,
  output logic [STRB_W-1:0]   wstrb,
  output logic [AXI_ID_W-1:0] wid,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  // B channel
  input  logic [AXI_ID_W-1:0] bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam logic [AXI_ID_W-1:0] INST_AXI_ID = AXI_ID_W'(INST_ID);
  localparam logic [AXI_ID_W-1:0] DATA_AXI_ID = AXI_ID_W'(DATA_ID);

  // AR slot
  logic                ar_busy_q;
  ax_req_t             ar_req_q;
  logic [AXI_ID_W-1:0] ar_id_q;

  // Per-port read-in-flight flags
  logic inst_rd_q;
  logic data_rd_q;

  logic inst_rd_go;
  logic data_rd_go;
  logic data_wr_go;
  logic inst_rsp;
  logic data_rsp;
  logic wr_idle;
  logic wr_done;

  // Error responses are not reported and single beats make rlast redundant
  logic unused_resp;
  assign unused_resp = ^{rresp, rlast, bresp};

  // The data port carries one read or one write at a time, keeping its
  // responses in order without any RAW tracking.
  assign data_rd_go = data_sram_req & ~data_sram_wr & ~ar_busy_q & ~data_rd_q & wr_idle;
  assign data_wr_go = data_sram_req &  data_sram_wr & ~data_rd_q & wr_idle;
  // Data reads take priority over inst reads for the shared AR slot
  assign inst_rd_go = inst_sram_req & ~inst_sram_wr & ~ar_busy_q & ~inst_rd_q & ~data_rd_go;

  assign inst_sram_addr_ok = inst_rd_go;
  assign data_sram_addr_ok = data_rd_go | data_wr_go;

  // Responses for a port with no read in flight are dropped
  assign inst_rsp = rvalid & (rid == INST_AXI_ID) & inst_rd_q;
  assign data_rsp = rvalid & (rid == DATA_AXI_ID) & data_rd_q;

  assign araddr  = ar_req_q.addr;
  assign arsize  = ar_req_q.size;
  assign arid    = ar_id_q;
  assign arvalid = ar_busy_q;
  assign arlen   = AXI_LEN_SINGLE;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;
  assign rready  = 1'b1;

  assign awlen   = AXI_LEN_SINGLE;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;
  assign bready  = 1'b1;

  // AR slot: load from the winning port, free on the arready edge
  always_ff @(posedge clk) begin
    if (reset) begin
      ar_busy_q <= 1'b0;
      ar_req_q  <= '0;
      ar_id_q   <= '0;
    end else if (ar_busy_q) begin
      if (arready) begin
        ar_busy_q <= 1'b0;
      end
    end else if (data_rd_go) begin
      ar_busy_q <= 1'b1;
      ar_req_q  <= '{addr: data_sram_addr, size: to_axsize(data_sram_size)};
      ar_id_q   <= DATA_AXI_ID;
    end else if (inst_rd_go) begin
      ar_busy_q <= 1'b1;
      ar_req_q  <= '{addr: inst_sram_addr, size: to_axsize(inst_sram_size)};
      ar_id_q   <= INST_AXI_ID;
    end
  end

  // Read-in-flight flags: set on accept, clear on the matching R beat
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_rd_q <= 1'b0;
      data_rd_q <= 1'b0;
    end else begin
      if (inst_rd_go) begin
        inst_rd_q <= 1'b1;
      end else if (inst_rsp) begin
        inst_rd_q <= 1'b0;
      end
      if (data_rd_go) begin
        data_rd_q <= 1'b1;
      end else if (data_rsp) begin
        data_rd_q <= 1'b0;
      end
    end
  end

  axi_bridge_wr_ch #(
    .AXI_ID_W (AXI_ID_W),
    .DATA_ID  (DATA_ID)
  ) u_wr_ch (
    .clk     (clk),
    .reset   (reset),
    .wr_go   (data_wr_go),
    .wr_addr (data_sram_addr),
    .wr_size (data_sram_size),
    .wr_strb (data_sram_wstrb),
    .wr_data (data_sram_wdata),
    .idle    (wr_idle),
    .done    (wr_done),
    .awaddr  (awaddr),
    .awid    (awid),
    .awsize  (awsize),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wid     (wid),
    .wlast   (wlast),
    .wvalid  (wvalid),
    .wready  (wready),
    .bid     (bid),
    .bvalid  (bvalid)
  );

`ifdef AXI_BRIDGE_RDATA_BUF_EN
  logic              inst_ok_q;
  logic [DATA_W-1:0] inst_rdata_q;
  logic              data_ok_q;
  logic [DATA_W-1:0] data_rdata_q;

  assign inst_sram_data_ok = inst_ok_q;
  assign inst_sram_rdata   = inst_rdata_q;
  assign data_sram_data_ok = data_ok_q;
  assign data_sram_rdata   = data_rdata_q;

  // Capture R/B responses per port for registered delivery
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_ok_q    <= 1'b0;
      inst_rdata_q <= '0;
      data_ok_q    <= 1'b0;
      data_rdata_q <= '0;
    end else begin
      inst_ok_q <= inst_rsp;
      data_ok_q <= data_rsp | wr_done;
      if (inst_rsp) begin
        inst_rdata_q <= rdata;
      end
      if (data_rsp) begin
        data_rdata_q <= rdata;
      end
    end
  end
`else
  assign inst_sram_data_ok = inst_rsp;
  assign inst_sram_rdata   = inst_rsp ? rdata : '0;
  assign data_sram_data_ok = data_rsp | wr_done;
  assign data_sram_rdata   = data_rsp ? rdata : '0;
`endif

endmodule

// File: tb/tb_axi_bridge.sv
// Directed bench for axi_bridge with a transaction-level reference model.
module tb_axi_bridge;

  localparam int ID_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            inst_sram_req, inst_sram_wr;
  logic [1:0]      inst_sram_size;
  logic [31:0]     inst_sram_addr;
  logic            inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0]     inst_sram_rdata;
  logic            data_sram_req, data_sram_wr;
  logic [1:0]      data_sram_size;
  logic [3:0]      data_sram_wstrb;
  logic [31:0]     data_sram_addr, data_sram_wdata;
  logic            data_sram_addr_ok, data_sram_data_ok;
  logic [31:0]     data_sram_rdata;
  logic [31:0]     araddr;
  logic [ID_W-1:0] arid;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst, arlock;
  logic [3:0]      arcache;
  logic [2:0]      arprot;
  logic            arvalid, arready;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast, rvalid, rready;
  logic [31:0]     awaddr;
  logic [ID_W-1:0] awid;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst, awlock;
  logic [3:0]      awcache;
  logic [2:0]      awprot;
  logic            awvalid, awready;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic [ID_W-1:0] wid;
  logic            wlast, wvalid, wready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid, bready;

  axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
    .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
    .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wid(wid), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    int          id;
    logic [1:0]  size;
  } ar_t;

  ar_t         ar_q[$];       // pending address phase (at most one)
  bit          busy[2];       // read in flight: [0] inst, [1] data
  bit          wr_out;        // write accepted, B not yet seen
  bit          aw_pend, w_pend;
  logic [31:0] m_awaddr, m_wdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_awsize;
  bit          q_inst_ok, q_data_ok, q_data_rok;
  logic [31:0] q_inst_rd, q_data_rd;
  bit          chk_en = 1'b0;

  function automatic bit want_data_rd();
    return data_sram_req && !data_sram_wr && ar_q.size() == 0 && !busy[1] && !wr_out;
  endfunction
  function automatic bit want_data_wr();
    return data_sram_req && data_sram_wr && !busy[1] && !wr_out;
  endfunction
  function automatic bit want_inst();
    return inst_sram_req && !inst_sram_wr && ar_q.size() == 0 && !busy[0] && !want_data_rd();
  endfunction
  function automatic bit resp_inst();
    return rvalid && rid == 0 && busy[0];
  endfunction
  function automatic bit resp_data();
    return rvalid && rid == 1 && busy[1];
  endfunction
  function automatic bit resp_b();
    return bvalid && bid == 1 && wr_out;
  endfunction

  always @(posedge clk) begin
    bit di, dr, dw, ri, rd, rb;
    if (reset) begin
      ar_q.delete();
      busy[0] = 0; busy[1] = 0;
      wr_out = 0; aw_pend = 0; w_pend = 0;
      q_inst_ok = 0; q_data_ok = 0; q_data_rok = 0;
      q_inst_rd = '0; q_data_rd = '0;
    end else begin
      di = want_inst(); dr = want_data_rd(); dw = want_data_wr();
      ri = resp_inst(); rd = resp_data(); rb = resp_b();
      q_inst_ok = ri; q_data_ok = rd || rb; q_data_rok = rd;
      if (ri) q_inst_rd = rdata;
      if (rd) q_data_rd = rdata;
      if (ar_q.size() != 0 && arready) void'(ar_q.pop_front());
      if (ri) busy[0] = 0;
      if (rd) busy[1] = 0;
      if (rb) wr_out = 0;
      if (aw_pend && awready) aw_pend = 0;
      if (w_pend && wready) w_pend = 0;
      if (dr) begin
        ar_q.push_back('{data_sram_addr, 1, data_sram_size});
        busy[1] = 1;
      end else if (di) begin
        ar_q.push_back('{inst_sram_addr, 0, inst_sram_size});
        busy[0] = 1;
      end
      if (dw) begin
        wr_out = 1; aw_pend = 1; w_pend = 1;
        m_awaddr = data_sram_addr; m_awsize = data_sram_size;
        m_wdata = data_sram_wdata; m_wstrb = data_sram_wstrb;
      end
    end
  end

  // Every-cycle comparison of all meaningful outputs against the model
  always @(negedge clk) begin
    bit e_iok, e_dok, e_drok;
    logic [31:0] e_ird, e_drd;
    if (chk_en) begin
      check("inst_addr_ok", inst_sram_addr_ok, want_inst());
      check("data_addr_ok", data_sram_addr_ok, want_data_rd() || want_data_wr());
      check("arvalid", arvalid, ar_q.size() != 0);
      if (ar_q.size() != 0) begin
        check("araddr", araddr, ar_q[0].addr);
        check("arid", arid, ar_q[0].id);
        check("arsize", arsize, {1'b0, ar_q[0].size});
      end
      check("awvalid", awvalid, aw_pend);
      if (aw_pend) begin
        check("awaddr", awaddr, m_awaddr);
        check("awsize", awsize, {1'b0, m_awsize});
        check("awid", awid, 1);
      end
      check("wvalid", wvalid, w_pend);
      if (w_pend) begin
        check("wdata", wdata, m_wdata);
        check("wstrb", wstrb, m_wstrb);
        check("wlast", wlast, 1);
        check("wid", wid, 1);
      end
      check("ax_const", {arlen, awlen, arburst, awburst, rready, bready},
            {8'd0, 8'd0, 2'b01, 2'b01, 1'b1, 1'b1});
`ifdef AXI_BRIDGE_RDATA_BUF_EN
      e_iok = q_inst_ok; e_ird = q_inst_rd;
      e_dok = q_data_ok; e_drok = q_data_rok; e_drd = q_data_rd;
`else
      e_iok = resp_inst(); e_ird = rdata;
      e_dok = resp_data() || resp_b(); e_drok = resp_data(); e_drd = rdata;
`endif
      check("inst_data_ok", inst_sram_data_ok, e_iok);
      if (e_iok) check("inst_rdata", inst_sram_rdata, e_ird);
      check("data_data_ok", data_sram_data_ok, e_dok);
      if (e_drok) check("data_rdata", data_sram_rdata, e_drd);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1;
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 0; inst_sram_addr = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 0; data_sram_wstrb = 0;
    data_sram_addr = 0; data_sram_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    chk_en = 1;
    #3;
    check("rst_arvalid", arvalid, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_data_ok", {inst_sram_data_ok, data_sram_data_ok}, 0);
    check("rst_rdata_i", inst_sram_rdata, 0);
    check("rst_rdata_d", data_sram_rdata, 0);

    // Test 1: single inst read, arready high
    step();
    inst_sram_req = 1; inst_sram_size = 2; inst_sram_addr = 32'h1c00_0000; arready = 1;
    #3 check("t1_addr_ok", inst_sram_addr_ok, 1);
    step();
    inst_sram_req = 0;
    #3 check("t1_arvalid", arvalid, 1);
    check("t1_araddr", araddr, 32'h1c00_0000);
    check("t1_arsize", arsize, 3'd2);
    step();
    arready = 0; rvalid = 1; rid = 0; rdata = 32'h0280_0000;
`ifndef AXI_BRIDGE_RDATA_BUF_EN
    #3 check("t1_data_ok_T2", inst_sram_data_ok, 1);
    check("t1_rdata", inst_sram_rdata, 32'h0280_0000);
    step();
    rvalid = 0;
    #3 check("t1_ok_drop", inst_sram_data_ok, 0);
`else
    #3 check("t1_no_ok_T2", inst_sram_data_ok, 0);
    step();
    rvalid = 0;
    #3 check("t1_data_ok_T3", inst_sram_data_ok, 1);
    check("t1_rdata", inst_sram_rdata, 32'h0280_0000);
`endif
    step();

    // Test 2: simultaneous inst and data reads, data wins
    inst_sram_req = 1; inst_sram_addr = 32'h1c00_0004; inst_sram_size = 2;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h0000_0200; data_sram_size = 2;
    #3 check("t2_data_win", data_sram_addr_ok, 1);
    check("t2_inst_lose", inst_sram_addr_ok, 0);
    step();
    data_sram_req = 0; arready = 1;
    #3 check("t2_arid_data", arid, 1);
    check("t2_inst_wait", inst_sram_addr_ok, 0);
    step();
    #3 check("t2_inst_ok", inst_sram_addr_ok, 1);
    step();
    inst_sram_req = 0;
    #3 check("t2_arid_inst", arid, 0);
    check("t2_araddr_inst", araddr, 32'h1c00_0004);
    // Test 5: back-to-back R beats for the two ids
    step();
    arready = 0; rvalid = 1; rid = 1; rdata = 32'hdada_0001;
`ifndef AXI_BRIDGE_RDATA_BUF_EN
    #3 check("t5_data_ok", {inst_sram_data_ok, data_sram_data_ok}, 2'b01);
    check("t5_data_rdata", data_sram_rdata, 32'hdada_0001);
`endif
    step();
    rid = 0; rdata = 32'h1111_0000;
`ifndef AXI_BRIDGE_RDATA_BUF_EN
    #3 check("t5_inst_ok", {inst_sram_data_ok, data_sram_data_ok}, 2'b10);
    check("t5_inst_rdata", inst_sram_rdata, 32'h1111_0000);
`endif
    step();
    rvalid = 0;
    step();

    // Test 3: data write, W accepted two cycles before AW
    data_sram_req = 1; data_sram_wr = 1; data_sram_size = 1; data_sram_addr = 32'h100;
    data_sram_wstrb = 4'b0011; data_sram_wdata = 32'h1234;
    #3 check("t3_addr_ok", data_sram_addr_ok, 1);
    step();
    data_sram_req = 0; data_sram_wr = 0; wready = 1;
    #3 check("t3_aw_w_valid", {awvalid, wvalid}, 2'b11);
    check("t3_awaddr", awaddr, 32'h100);
    check("t3_wstrb", wstrb, 4'b0011);
    check("t3_wdata", wdata, 32'h1234);
    // Test 4: data read while the write is still outstanding
    step();
    wready = 0;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h300; data_sram_size = 2;
    #3 check("t3_w_drop", {awvalid, wvalid}, 2'b10);
    check("t4_blocked_a", data_sram_addr_ok, 0);
    step();
    awready = 1;
    #3 check("t4_blocked_b", data_sram_addr_ok, 0);
    step();
    awready = 0;
    #3 check("t3_aw_drop", awvalid, 0);
    check("t3_no_early_ok", data_sram_data_ok, 0);
    step();
    bvalid = 1; bid = 1;
    #3 check("t4_blocked_at_b", data_sram_addr_ok, 0);
`ifndef AXI_BRIDGE_RDATA_BUF_EN
    check("t3_b_ok", data_sram_data_ok, 1);
`endif
    step();
    bvalid = 0; arready = 1;
    #3 check("t4_accept", data_sram_addr_ok, 1);
    step();
    data_sram_req = 0;
    #3 check("t4_araddr", araddr, 32'h300);
    step();
    arready = 0; rvalid = 1; rid = 1; rdata = 32'hcafe_0300;
    step();
    rvalid = 0;
    step();

    // Test 6: reset with a read outstanding, stale R beat must be dropped
    inst_sram_req = 1; inst_sram_addr = 32'h1c00_0040; inst_sram_size = 2; arready = 1;
    step();
    inst_sram_req = 0;
    step();
    arready = 0; reset = 1;
    step();
    reset = 0; rvalid = 1; rid = 0; rdata = 32'hbad0_bad0;
    #3 check("t6_dropped", inst_sram_data_ok, 0);
    step();
    rvalid = 0;
    inst_sram_req = 1; inst_sram_addr = 32'h1c00_0080; arready = 1;
    #3 check("t6_accept", inst_sram_addr_ok, 1);
    check("t6_no_late_ok", inst_sram_data_ok, 0);
    step();
    inst_sram_req = 0;
    step();
    arready = 0; rvalid = 1; rid = 0; rdata = 32'h600d_600d;
    step();
    rid = 3; rdata = 32'hdead_beef;   // unknown id
    #3 check("t6_bad_id", {inst_sram_data_ok, data_sram_data_ok}, 2'b00);
    step();
    rvalid = 0;
    repeat (3) step();

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
